// File: rtl/riscv_wb_arb_pkg.sv
// rtl/riscv_wb_arb_pkg.sv - shared widths, entry type and mask helper for the writeback arbiter
`ifndef XLEN
`define XLEN 32
`endif
`ifndef RF_ADDR_W
`define RF_ADDR_W 5
`endif
`ifndef RF_NREGS
`define RF_NREGS 32
`endif

package riscv_wb_arb_pkg;

  localparam int XLEN      = `XLEN;
  localparam int RF_ADDR_W = `RF_ADDR_W;
  localparam int RF_NREGS  = `RF_NREGS;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [XLEN-1:0]      rf_data_t;

  typedef struct packed {
    rf_addr_t rd;
    rf_data_t data;
  } wb_entry_t;

  function automatic logic [RF_NREGS-1:0] rd_onehot(input rf_addr_t rd);
    logic [RF_NREGS-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/riscv_wb_arb_if.sv
// rtl/riscv_wb_arb_if.sv - pipeline/LL writeback inputs and register-file port of the arbiter
interface riscv_wb_arb_if;
  import riscv_wb_arb_pkg::*;

  logic                wb_valid;
  rf_addr_t            wb_rd_addr;
  rf_data_t            wb_rd_data;
  logic                ll_valid;
  logic                ll_ready;
  rf_addr_t            ll_rd_addr;
  rf_data_t            ll_rd_data;
  logic                rf_we;
  rf_addr_t            rf_waddr;
  rf_data_t            rf_wdata;
  logic                wb_stall;
  logic [RF_NREGS-1:0] ll_pend_mask;

  modport master (
    output wb_valid, wb_rd_addr, wb_rd_data,
    output ll_valid, ll_rd_addr, ll_rd_data,
    input  ll_ready,
    input  rf_we, rf_waddr, rf_wdata,
    input  wb_stall, ll_pend_mask
  );

  modport slave (
    input  wb_valid, wb_rd_addr, wb_rd_data,
    input  ll_valid, ll_rd_addr, ll_rd_data,
    output ll_ready,
    output rf_we, rf_waddr, rf_wdata,
    output wb_stall, ll_pend_mask
  );

endinterface

// File: rtl/riscv_wb_fifo.sv
// rtl/riscv_wb_fifo.sv - holding FIFO for LL results with per-entry valid/rd view
module riscv_wb_fifo
  import riscv_wb_arb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic [DEPTH-1:0] ent_vld,
  output rf_addr_t         ent_rd [DEPTH]
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [DEPTH-1:0] vld_next;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Push and pop never target the same slot: both need 0 < count < DEPTH.
  always_comb begin
    vld_next = ent_vld;
    if (do_pop)
      vld_next[rd_ptr] = 1'b0;
    if (do_push)
      vld_next[wr_ptr] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      ent_rd[i] = mem[i].rd;
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst)
      mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ent_vld <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)
        count <= count + CNT_W'(1);
      else if (do_pop && !do_push)
        count <= count - CNT_W'(1);
      ent_vld <= vld_next;
    end
  end

endmodule

// File: rtl/riscv_wb_arb.sv
// rtl/riscv_wb_arb.sv - register-file write port arbiter: pipeline first, LL results buffered and drained
module riscv_wb_arb
  import riscv_wb_arb_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic           i_clk,
  input logic           i_rst,
  riscv_wb_arb_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t           head;
  logic [CNT_W-1:0]    count;
  logic                full;
  logic                empty;
  logic [DEPTH-1:0]    ent_vld;
  rf_addr_t            ent_rd [DEPTH];

  logic [STV_W-1:0]    starve_q;
  logic [STV_W-1:0]    starve_d;
  logic                stall_q;
  logic                stall_d;

  logic                pw;
  logic                ll_acc;
  logic                ll_nz;
  logic                pop;
  logic                bypass;
  logic                push;
  logic [RF_NREGS-1:0] mask;

  riscv_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (i_clk),
    .rst        (i_rst),
    .push       (push),
    .push_entry ('{rd: bus.ll_rd_addr, data: bus.ll_rd_data}),
    .pop        (pop),
    .head       (head),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .ent_vld    (ent_vld),
    .ent_rd     (ent_rd)
  );

  // Readiness looks only at the start-of-cycle count, so a full FIFO never pops and pushes together.
  assign bus.ll_ready = (count < CNT_W'(DEPTH)) && !i_rst;

  always_comb begin
    pw     = bus.wb_valid && (bus.wb_rd_addr != '0) && !stall_q;
    ll_acc = bus.ll_valid && !full && !i_rst;
    ll_nz  = (bus.ll_rd_addr != '0);
    pop    = !pw && !empty && !i_rst;
    bypass = !pw && empty && ll_acc && ll_nz;
    push   = ll_acc && ll_nz && !bypass;
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    if (!i_rst) begin
      if (pw) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.wb_rd_addr;
        bus.rf_wdata = bus.wb_rd_data;
      end else if (!empty) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = head.rd;
        bus.rf_wdata = head.data;
      end else if (bypass) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.ll_rd_addr;
        bus.rf_wdata = bus.ll_rd_data;
      end
    end
  end

  // The blocked cycle that reaches the limit arms a one-cycle freeze; the freeze cycle always pops.
  always_comb begin
    starve_d = '0;
    stall_d  = 1'b0;
    if (!empty && !pop) begin
      if (starve_q == STV_W'(STARVE_LIMIT - 1))
        stall_d = 1'b1;
      else
        starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.wb_stall = stall_q;

  // Built purely from the FIFO's entry flops, so it moves only on the clock edge with the FIFO.
  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i])
        mask = mask | rd_onehot(ent_rd[i]);
    end
    mask[0] = 1'b0;
  end

  assign bus.ll_pend_mask = mask;

endmodule
